// File: rtl/sc_div_seq.sv
// Sequential stochastic-computing divider: a saturating feedback counter tracks
// dividend/divisor, sampled against rand_num to emit the quotient bitstream.
module sc_div_seq #(
  parameter int CNT_W  = 6,
  parameter int LEN_W  = 16,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] init_val,
  input  logic [LEN_W-1:0] stream_len,
  input  logic [CNT_W-1:0] rand_num,
  input  logic             dividend,
  input  logic             divisor,
  output logic             quotient,
  output logic             quotient_vld,
  output logic             busy,
  output logic             done,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WARM = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WU_W-1:0]  WU_LAST = WU_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MID = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic             mode_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] run_cnt;
  logic [WU_W-1:0]  wu_cnt;

  logic             q, b, inc, dec, blk_hi, blk_lo;
  logic [CNT_W-1:0] cnt_nxt;

  // Feedback: the counter settles where q*divisor matches the dividend density.
  always_comb begin
    q       = (cnt >= rand_num);
    b       = mode_r ? ~(q ^ divisor) : (q & divisor);
    inc     = dividend & ~b;
    dec     = ~dividend & b;
    blk_hi  = inc && (cnt == CNT_MAX);
    blk_lo  = dec && (cnt == '0);
    cnt_nxt = cnt;
    if (inc && !blk_hi)      cnt_nxt = cnt + CNT_W'(1);
    else if (dec && !blk_lo) cnt_nxt = cnt - CNT_W'(1);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= CNT_MID;
      mode_r       <= 1'b0;
      len_r        <= '0;
      run_cnt      <= '0;
      wu_cnt       <= '0;
      quotient     <= 1'b0;
      quotient_vld <= 1'b0;
      done         <= 1'b0;
      sat_hi       <= 1'b0;
      sat_lo       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) begin
        cnt    <= cnt_nxt;
        sat_hi <= sat_hi | blk_hi;
        sat_lo <= sat_lo | blk_lo;
      end
      case (state)
        S_IDLE: begin
          quotient     <= 1'b0;
          quotient_vld <= 1'b0;
          if (start) begin
            cnt     <= init_val;
            mode_r  <= mode;
            len_r   <= stream_len;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
            run_cnt <= '0;
            wu_cnt  <= '0;
            if (WARMUP > 0)            state <= S_WARM;
            else if (stream_len == '0) done  <= 1'b1;
            else                       state <= S_RUN;
          end
        end
        S_WARM: begin
          quotient     <= 1'b0;
          quotient_vld <= 1'b0;
          if (wu_cnt == WU_LAST) begin
            if (len_r == '0) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            wu_cnt <= wu_cnt + WU_W'(1);
          end
        end
        S_RUN: begin
          quotient     <= q;
          quotient_vld <= 1'b1;
          if (run_cnt == len_r - LEN_W'(1)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            run_cnt <= run_cnt + LEN_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_div_seq.sv
// Bench for sc_div_seq: two instances (WARMUP=4 and WARMUP=0) share stimulus and are
// checked every cycle against a cycle-count model, plus literal timing/saturation points.
module tb_sc_div_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, mode, dividend, divisor;
  logic [5:0]  init_val, rand_num;
  logic [15:0] stream_len;

  logic       quo_o[2], vld_o[2], busy_o[2], done_o[2], sh_o[2], sl_o[2];
  logic [5:0] cnt_o[2];

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    sc_div_seq #(.CNT_W(6), .LEN_W(16), .WARMUP(k == 0 ? 4 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .init_val(init_val),
      .stream_len(stream_len), .rand_num(rand_num), .dividend(dividend), .divisor(divisor),
      .quotient(quo_o[k]), .quotient_vld(vld_o[k]), .busy(busy_o[k]), .done(done_o[k]),
      .sat_hi(sh_o[k]), .sat_lo(sl_o[k]), .cnt(cnt_o[k]));
  end

  function automatic int wu(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  // Net counter change requested this cycle: +1, -1 or 0 (before saturation).
  function automatic int f_d(input int c, input bit md);
    bit qb, bb;
    qb = (c >= int'(rand_num));
    bb = md ? (qb == divisor) : (qb && divisor);
    return int'(dividend) - int'(bb);
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Model: a run is W+L busy cycles after the start edge; the last L are run beats.
  int m_cnt[2], m_len[2], m_n[2];
  bit m_busy[2], m_vld[2], m_q[2], m_done[2], m_sh[2], m_sl[2], m_mode[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] <= 32; m_len[k] <= 0; m_n[k] <= 0; m_busy[k] <= 0; m_vld[k] <= 0;
        m_q[k] <= 0; m_done[k] <= 0; m_sh[k] <= 0; m_sl[k] <= 0; m_mode[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          m_vld[k] <= 0; m_q[k] <= 0; m_done[k] <= 0;
          if (start) begin
            m_cnt[k] <= int'(init_val); m_mode[k] <= mode; m_len[k] <= int'(stream_len);
            m_sh[k] <= 0; m_sl[k] <= 0; m_n[k] <= 0;
            if (wu(k) + int'(stream_len) == 0) m_done[k] <= 1;
            else m_busy[k] <= 1;
          end
        end else begin
          if (m_cnt[k] + f_d(m_cnt[k], m_mode[k]) > 63)    m_sh[k] <= 1;
          else if (m_cnt[k] + f_d(m_cnt[k], m_mode[k]) < 0) m_sl[k] <= 1;
          else m_cnt[k] <= m_cnt[k] + f_d(m_cnt[k], m_mode[k]);
          m_vld[k] <= (m_n[k] >= wu(k));
          m_q[k]   <= (m_n[k] >= wu(k)) && (m_cnt[k] >= int'(rand_num));
          if (m_n[k] + 1 == wu(k) + m_len[k]) begin
            m_busy[k] <= 0; m_done[k] <= 1;
          end else begin
            m_done[k] <= 0;
          end
          m_n[k] <= m_n[k] + 1;
        end
      end
    end
  end

  int vld_beats[2] = '{0, 0};
  int one_beats[2] = '{0, 0};
  int done_beats[2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("busy", k, busy_o[k], m_busy[k]);
      chk("quotient_vld", k, vld_o[k], m_vld[k]);
      chk("quotient", k, quo_o[k], m_q[k]);
      chk("done", k, done_o[k], m_done[k]);
      chk("sat_hi", k, sh_o[k], m_sh[k]);
      chk("sat_lo", k, sl_o[k], m_sl[k]);
      chk("cnt", k, cnt_o[k], m_cnt[k]);
      if (vld_o[k]) vld_beats[k]++;
      if (vld_o[k] && quo_o[k]) one_beats[k]++;
      if (done_o[k]) done_beats[k]++;
    end
  end

  task automatic step(input bit s);
    @(posedge clk); #1;
    start = s;
    if (rnd_en) begin
      dividend = 1'($urandom); divisor = 1'($urandom); rand_num = 6'($urandom);
    end
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && (busy_o[0] || busy_o[1]); i++) step(1'b0);
    chk("idle_timeout", 0, int'(busy_o[0] | busy_o[1]), 0);
    step(1'b0);
  endtask

  int b_v[2], b_o[2], b_d[2];

  initial begin
    rst_n = 0; start = 0; mode = 0; init_val = 0; stream_len = 0;
    rand_num = 0; dividend = 0; divisor = 0;
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("rst_cnt", k, cnt_o[k], 32);
      chk("rst_busy", k, busy_o[k], 0);
      chk("rst_done", k, done_o[k], 0);
    end
    step(1'b0); rst_n = 1;
    step(1'b0);

    // Unipolar hold: dividend=divisor=1, rand 0 -> b=1, no movement.
    mode = 0; init_val = 32; stream_len = 10; dividend = 1; divisor = 1; rand_num = 0;
    for (int k = 0; k < 2; k++) begin b_v[k] = vld_beats[k]; b_o[k] = one_beats[k]; end
    step(1'b1);
    for (int c = 0; c < 16; c++) begin
      at_neg();
      chk("hold_cnt", 1, cnt_o[1], 32);
      step(1'b0);
    end
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      chk("hold_beats", k, vld_beats[k] - b_v[k], 10);
      chk("hold_ones", k, one_beats[k] - b_o[k], 10);
      chk("hold_cnt_end", k, cnt_o[k], 32);
    end

    // Saturate high: 62 -> 63 on first update, blocked on the second.
    init_val = 62; stream_len = 5; dividend = 1; divisor = 0; rand_num = 63;
    step(1'b1);
    for (int c = 0; c < 5; c++) begin
      at_neg();
      if (c >= 1 && c <= 3) begin
        for (int k = 0; k < 2; k++) begin
          chk("sh_cnt", k, cnt_o[k], (c == 1) ? 62 : 63);
          chk("sh_flag", k, sh_o[k], (c >= 3) ? 1 : 0);
          chk("sh_lo", k, sl_o[k], 0);
        end
      end
      step(1'b0);
    end
    wait_idle();

    // Bipolar saturate low: q=0, b=1, 32 decrements to 0, then blocked.
    mode = 1; init_val = 32; stream_len = 40; dividend = 0; divisor = 0; rand_num = 63;
    step(1'b1);
    for (int c = 0; c < 36; c++) begin
      at_neg();
      for (int k = 0; k < 2; k++) begin
        if (c == 1)  chk("sl_clr_hi", k, sh_o[k], 0);
        if (c == 32) chk("sl_cnt32", k, cnt_o[k], 1);
        if (c == 33) begin chk("sl_cnt33", k, cnt_o[k], 0); chk("sl_flag33", k, sl_o[k], 0); end
        if (c == 34) begin chk("sl_flag34", k, sl_o[k], 1); chk("sl_cnt34", k, cnt_o[k], 0); end
      end
      step(1'b0);
    end
    wait_idle();

    // Handshake timing on the WARMUP=4 instance; restart at cycle 7 is ignored.
    rnd_en = 1; mode = 0; init_val = 20; stream_len = 8;
    step(1'b1);
    for (int c = 0; c < 16; c++) begin
      at_neg();
      chk("tm_busy", 0, busy_o[0], (c >= 1 && c <= 12) ? 1 : 0);
      chk("tm_vld", 0, vld_o[0], (c >= 6 && c <= 13) ? 1 : 0);
      chk("tm_done", 0, done_o[0], (c == 13) ? 1 : 0);
      chk("tm_busy_w0", 1, busy_o[1], (c >= 1 && c <= 8) ? 1 : 0);
      if (c + 1 == 7) begin init_val = 5; stream_len = 2; mode = 1; end
      step(c + 1 == 7);
    end
    wait_idle();

    // Zero length.
    stream_len = 0;
    step(1'b1);
    for (int c = 0; c < 8; c++) begin
      at_neg();
      chk("z_busy", 0, busy_o[0], (c >= 1 && c <= 4) ? 1 : 0);
      chk("z_done", 0, done_o[0], (c == 5) ? 1 : 0);
      chk("z_vld", 0, vld_o[0], 0);
      chk("z_busy_w0", 1, busy_o[1], 0);
      chk("z_done_w0", 1, done_o[1], (c == 1) ? 1 : 0);
      step(1'b0);
    end

    // Random configurations, checked by the model every cycle.
    for (int r = 0; r < 6; r++) begin
      mode = 1'($urandom); init_val = 6'($urandom); stream_len = 16'($urandom_range(1, 12));
      step(1'b1);
      step(1'b0);
      wait_idle();
    end

    // Reset mid-run aborts with no done pulse.
    rnd_en = 0; mode = 0; init_val = 60; stream_len = 20;
    dividend = 1; divisor = 0; rand_num = 63;
    step(1'b1);
    repeat (8) step(1'b0);
    rst_n = 0;
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("mr_cnt", k, cnt_o[k], 32);
      chk("mr_busy", k, busy_o[k], 0);
      chk("mr_vld", k, vld_o[k], 0);
      chk("mr_sat_hi", k, sh_o[k], 0);
      b_d[k] = done_beats[k];
    end
    step(1'b0); rst_n = 1;
    repeat (25) step(1'b0);
    for (int k = 0; k < 2; k++) chk("mr_no_done", k, done_beats[k] - b_d[k], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
